// File: rtl/as_pack.sv
// as_pack: shared definitions for the I-Mem debug loader.
//   - loader opcode and FSM state enums (3 bit each)
//   - scan command field offsets ({addr, data, op})
//   - default widths, tied to the codebase-wide instr/address widths
package as_pack;

    localparam int instr_width     = 32;
    localparam int imem_addr_width = 10;

    localparam int INSTR_W_DEF = instr_width;
    localparam int IMEM_AW_DEF = imem_addr_width;

    // Command layout: op in the low bits, data above it, address on top.
    localparam int OP_W     = 3;
    localparam int OP_LSB   = 0;
    localparam int DATA_LSB = OP_LSB + OP_W;

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_OPEN    = 3'b001,
        OP_SETADDR = 3'b010,
        OP_WRITE   = 3'b011,
        OP_READ    = 3'b100,
        OP_CLOSE   = 3'b101,
        OP_ILL6    = 3'b110,
        OP_ILL7    = 3'b111
    } ld_op_e;

    // Encoding is visible in status_o, so values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD_WAIT = 3'd1,
        ST_OWN       = 3'd2,
        ST_WRITE     = 3'd3,
        ST_READ      = 3'd4,
        ST_RELEASE   = 3'd5
    } ld_state_e;

endpackage

// File: rtl/as_sync_bit.sv
// as_sync_bit: STAGES-deep flop synchroniser for a single asynchronous bit.
// Ports:
//   tck_i      destination clock
//   tap_rst_s  asynchronous active-high reset, clears every stage
//   d_i        asynchronous input
//   q_o        synchronised output (STAGES tck cycles of latency)
module as_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic tck_i,
    input  logic tap_rst_s,
    input  logic d_i,
    output logic q_o
);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic stage_in;
            logic stage_reg;

            if (gi == 0) begin : g_first
                assign stage_in = d_i;
            end else begin : g_next
                assign stage_in = g_stage[gi-1].stage_reg;
            end

            always_ff @(posedge tck_i or posedge tap_rst_s) begin
                if (tap_rst_s) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= stage_in;
                end
            end
        end
    endgenerate

    assign q_o = g_stage[STAGES-1].stage_reg;

endmodule

// File: rtl/as_imem_loader.sv
// as_imem_loader: JTAG-side controller that takes the single I-Mem port away
// from CPU fetch (hold/ack handshake) and performs word writes and readbacks
// from decoded scan-chain commands. Runs entirely on tck_i.
// Ports:
//   tck_i, tap_rst_s   clock, asynchronous active-high reset
//   upd_i, cmd_i       update-DR pulse and {addr, data, op} command
//   cpu_ack_i          CPU hold acknowledge (asynchronous, synchronised here)
//   cpu_hold_o         request CPU to stop fetching
//   cpu_restart_o      one-tck pulse when the CPU is released
//   imem_sel_o         loader owns the I-Mem address
//   imem_addr_o        loader pointer
//   imem_data_o        last WRITE data
//   imem_wr_o          single-cycle write strobe
//   imem_data_i        I-Mem read data
//   status_o           registered {rdata, ptr, wr_cnt, state, wrap, ovr, cmd_err, owned}
module as_imem_loader
    import as_pack::*;
#(
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int IMEM_AW     = IMEM_AW_DEF,
    parameter int CMD_W       = 3 + INSTR_W + IMEM_AW,
    parameter int READ_LAT    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        tck_i,
    input  logic                        tap_rst_s,
    input  logic                        upd_i,
    input  logic [CMD_W-1:0]            cmd_i,
    input  logic                        cpu_ack_i,
    output logic                        cpu_hold_o,
    output logic                        cpu_restart_o,
    output logic                        imem_sel_o,
    output logic [IMEM_AW-1:0]          imem_addr_o,
    output logic [INSTR_W-1:0]          imem_data_o,
    output logic                        imem_wr_o,
    input  logic [INSTR_W-1:0]          imem_data_i,
    output logic [INSTR_W+IMEM_AW+22:0] status_o
);

    localparam int ADDR_LSB = DATA_LSB + INSTR_W;
    localparam int STATUS_W = INSTR_W + IMEM_AW + 23;
    localparam logic [1:0]         LAT_LAST = 2'(READ_LAT - 1);
    localparam logic [IMEM_AW-1:0] PTR_ONE  = IMEM_AW'(1);

    ld_op_e               cmd_op;
    logic [INSTR_W-1:0]   cmd_data;
    logic [IMEM_AW-1:0]   cmd_addr;
    logic                 ack_sync;

    assign cmd_op   = ld_op_e'(cmd_i[OP_LSB +: OP_W]);
    assign cmd_data = cmd_i[DATA_LSB +: INSTR_W];
    assign cmd_addr = cmd_i[ADDR_LSB +: IMEM_AW];

    as_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .tck_i     (tck_i),
        .tap_rst_s (tap_rst_s),
        .d_i       (cpu_ack_i),
        .q_o       (ack_sync)
    );

    ld_state_e            state_reg,   state_next;
    logic                 hold_reg,    hold_next;
    logic                 sel_reg,     sel_next;
    logic                 wr_reg,      wr_next;
    logic                 restart_reg, restart_next;
    logic [IMEM_AW-1:0]   ptr_reg,     ptr_next;
    logic [INSTR_W-1:0]   data_reg,    data_next;
    logic [INSTR_W-1:0]   rdata_reg,   rdata_next;
    logic [15:0]          wr_cnt_reg,  wr_cnt_next;
    logic                 wrap_reg,    wrap_next;
    logic                 ovr_reg,     ovr_next;
    logic                 cmd_err_reg, cmd_err_next;
    logic [1:0]           lat_reg,     lat_next;
    logic [STATUS_W-1:0]  status_reg;

    always_ff @(posedge tck_i or posedge tap_rst_s) begin
        if (tap_rst_s) begin
            state_reg   <= ST_IDLE;
            hold_reg    <= 1'b0;
            sel_reg     <= 1'b0;
            wr_reg      <= 1'b0;
            restart_reg <= 1'b0;
            ptr_reg     <= '0;
            data_reg    <= '0;
            rdata_reg   <= '0;
            wr_cnt_reg  <= '0;
            wrap_reg    <= 1'b0;
            ovr_reg     <= 1'b0;
            cmd_err_reg <= 1'b0;
            lat_reg     <= '0;
            status_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            sel_reg     <= sel_next;
            wr_reg      <= wr_next;
            restart_reg <= restart_next;
            ptr_reg     <= ptr_next;
            data_reg    <= data_next;
            rdata_reg   <= rdata_next;
            wr_cnt_reg  <= wr_cnt_next;
            wrap_reg    <= wrap_next;
            ovr_reg     <= ovr_next;
            cmd_err_reg <= cmd_err_next;
            lat_reg     <= lat_next;
            status_reg  <= {rdata_reg, ptr_reg, wr_cnt_reg, state_reg,
                            wrap_reg, ovr_reg, cmd_err_reg, sel_reg};
        end
    end

    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        sel_next     = sel_reg;
        wr_next      = 1'b0;
        restart_next = 1'b0;
        ptr_next     = ptr_reg;
        data_next    = data_reg;
        rdata_next   = rdata_reg;
        wr_cnt_next  = wr_cnt_reg;
        wrap_next    = wrap_reg;
        ovr_next     = ovr_reg;
        cmd_err_next = cmd_err_reg;
        lat_next     = lat_reg;

        case (state_reg)
            ST_IDLE: begin
                if (upd_i) begin
                    case (cmd_op)
                        OP_NOP: ;
                        OP_OPEN: begin
                            // A fresh session starts with clean error flags.
                            state_next   = ST_HOLD_WAIT;
                            hold_next    = 1'b1;
                            ovr_next     = 1'b0;
                            cmd_err_next = 1'b0;
                        end
                        default: cmd_err_next = 1'b1;
                    endcase
                end
            end

            ST_HOLD_WAIT: begin
                // CLOSE wins over a simultaneous ack: the session is abandoned.
                if (upd_i && cmd_op == OP_CLOSE) begin
                    state_next = ST_RELEASE;
                end else begin
                    if (upd_i && (cmd_op == OP_ILL6 || cmd_op == OP_ILL7)) begin
                        cmd_err_next = 1'b1;
                    end
                    if (ack_sync) begin
                        state_next = ST_OWN;
                        sel_next   = 1'b1;
                    end
                end
            end

            ST_OWN: begin
                if (upd_i) begin
                    case (cmd_op)
                        OP_SETADDR: begin
                            ptr_next  = cmd_addr;
                            wrap_next = 1'b0;
                        end
                        OP_WRITE: begin
                            // Strobe and data become visible together in the WRITE cycle.
                            state_next = ST_WRITE;
                            wr_next    = 1'b1;
                            data_next  = cmd_data;
                        end
                        OP_READ: begin
                            state_next = ST_READ;
                            lat_next   = '0;
                        end
                        OP_CLOSE: begin
                            state_next = ST_RELEASE;
                            sel_next   = 1'b0;
                        end
                        OP_ILL6, OP_ILL7: cmd_err_next = 1'b1;
                        default: ;
                    endcase
                end
            end

            ST_WRITE: begin
                if (upd_i) begin
                    ovr_next = 1'b1;
                end
                ptr_next = ptr_reg + PTR_ONE;
                if (&ptr_reg) begin
                    wrap_next = 1'b1;
                end
                if (wr_cnt_reg != 16'hFFFF) begin
                    wr_cnt_next = wr_cnt_reg + 16'd1;
                end
                state_next = ST_OWN;
            end

            ST_READ: begin
                if (upd_i) begin
                    ovr_next = 1'b1;
                end
                // The address has been stable since entry; sample after READ_LAT cycles.
                if (lat_reg == LAT_LAST) begin
                    rdata_next = imem_data_i;
                    ptr_next   = ptr_reg + PTR_ONE;
                    if (&ptr_reg) begin
                        wrap_next = 1'b1;
                    end
                    state_next = ST_OWN;
                end else begin
                    lat_next = lat_reg + 2'd1;
                end
            end

            ST_RELEASE: begin
                // Select already dropped on entry; the CPU is let go one cycle later.
                if (upd_i) begin
                    ovr_next = 1'b1;
                end
                sel_next     = 1'b0;
                hold_next    = 1'b0;
                restart_next = 1'b1;
                state_next   = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                sel_next   = 1'b0;
                hold_next  = 1'b0;
            end
        endcase
    end

    assign cpu_hold_o    = hold_reg;
    assign cpu_restart_o = restart_reg;
    assign imem_sel_o    = sel_reg;
    assign imem_addr_o   = ptr_reg;
    assign imem_data_o   = data_reg;
    assign imem_wr_o     = wr_reg;
    assign status_o      = status_reg;

endmodule

// File: tb/tb_as_imem_loader.sv
module tb_as_imem_loader;

    localparam int INSTR_W  = 32;
    localparam int IMEM_AW  = 10;
    localparam int CMD_W    = 3 + INSTR_W + IMEM_AW;
    localparam int STATUS_W = INSTR_W + IMEM_AW + 23;

    localparam logic [2:0] C_NOP = 3'b000, C_OPEN = 3'b001, C_SETADDR = 3'b010,
                           C_WRITE = 3'b011, C_READ = 3'b100, C_CLOSE = 3'b101,
                           C_ILL7 = 3'b111;

    logic                tck_i = 1'b0;
    logic                tap_rst_s = 1'b1;
    logic                upd_i = 1'b0;
    logic [CMD_W-1:0]    cmd_i = '0;
    logic                cpu_ack_i = 1'b0;
    logic                cpu_hold_o;
    logic                cpu_restart_o;
    logic                imem_sel_o;
    logic [IMEM_AW-1:0]  imem_addr_o;
    logic [INSTR_W-1:0]  imem_data_o;
    logic                imem_wr_o;
    logic [INSTR_W-1:0]  imem_data_i;
    logic [STATUS_W-1:0] status_o;

    as_imem_loader dut (
        .tck_i         (tck_i),
        .tap_rst_s     (tap_rst_s),
        .upd_i         (upd_i),
        .cmd_i         (cmd_i),
        .cpu_ack_i     (cpu_ack_i),
        .cpu_hold_o    (cpu_hold_o),
        .cpu_restart_o (cpu_restart_o),
        .imem_sel_o    (imem_sel_o),
        .imem_addr_o   (imem_addr_o),
        .imem_data_o   (imem_data_o),
        .imem_wr_o     (imem_wr_o),
        .imem_data_i   (imem_data_i),
        .status_o      (status_o)
    );

    always #5 tck_i = ~tck_i;

    // I-Mem model (registered read, READ_LAT=1) plus bus monitors.
    logic [INSTR_W-1:0] mem [0:(1<<IMEM_AW)-1];
    logic [INSTR_W-1:0] mem_q = '0;
    int                 wr_total = 0;
    int                 restart_total = 0;
    int                 inv_viol = 0;
    logic [IMEM_AW-1:0] last_wr_addr = '0;
    logic [INSTR_W-1:0] last_wr_data = '0;

    assign imem_data_i = mem_q;

    always @(posedge tck_i) begin
        mem_q <= mem[imem_addr_o];
        if (imem_wr_o) begin
            mem[imem_addr_o] <= imem_data_o;
            wr_total     <= wr_total + 1;
            last_wr_addr <= imem_addr_o;
            last_wr_data <= imem_data_o;
        end
        if (cpu_restart_o) restart_total <= restart_total + 1;
        if ((imem_wr_o && !imem_sel_o) || (imem_sel_o && !cpu_hold_o)) inv_viol <= inv_viol + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Status field accessors
    function automatic logic        s_owned(input logic [STATUS_W-1:0] s); return s[0]; endfunction
    function automatic logic        s_err  (input logic [STATUS_W-1:0] s); return s[1]; endfunction
    function automatic logic        s_ovr  (input logic [STATUS_W-1:0] s); return s[2]; endfunction
    function automatic logic        s_wrap (input logic [STATUS_W-1:0] s); return s[3]; endfunction
    function automatic logic [2:0]  s_state(input logic [STATUS_W-1:0] s); return s[6:4]; endfunction
    function automatic logic [15:0] s_cnt  (input logic [STATUS_W-1:0] s); return s[22:7]; endfunction
    function automatic logic [9:0]  s_ptr  (input logic [STATUS_W-1:0] s); return s[32:23]; endfunction
    function automatic logic [31:0] s_rdata(input logic [STATUS_W-1:0] s); return s[64:33]; endfunction

    // Called at a negedge; returns at the following negedge with upd_i low.
    task automatic send(input logic [2:0] op, input logic [9:0] a, input logic [31:0] d);
        cmd_i = {a, d, op};
        upd_i = 1'b1;
        @(negedge tck_i);
        upd_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge tck_i);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [9:0]  exp_ptr;
        logic        exp_wrap;
        logic [15:0] exp_cnt;
        logic [31:0] exp_rdata;
        int          exp_wr;
        logic [9:0]  exp_wr_addr;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int wr_before;
        int rs_before;
        bit got;

        vecs[0] = '{C_SETADDR, 10'h010, 32'h0,        10'h010, 1'b0, 16'd0, 32'h0,        0, 10'h000};
        vecs[1] = '{C_WRITE,   10'h000, 32'hDEADBEEF, 10'h011, 1'b0, 16'd1, 32'h0,        1, 10'h010};
        vecs[2] = '{C_WRITE,   10'h000, 32'h00000013, 10'h012, 1'b0, 16'd2, 32'h0,        1, 10'h011};
        vecs[3] = '{C_SETADDR, 10'h010, 32'h0,        10'h010, 1'b0, 16'd2, 32'h0,        0, 10'h000};
        vecs[4] = '{C_READ,    10'h000, 32'h0,        10'h011, 1'b0, 16'd2, 32'hDEADBEEF, 0, 10'h000};
        vecs[5] = '{C_READ,    10'h000, 32'h0,        10'h012, 1'b0, 16'd2, 32'h00000013, 0, 10'h000};
        vecs[6] = '{C_SETADDR, 10'h3FF, 32'h0,        10'h3FF, 1'b0, 16'd2, 32'h00000013, 0, 10'h000};
        vecs[7] = '{C_WRITE,   10'h000, 32'h00000001, 10'h000, 1'b1, 16'd3, 32'h00000013, 1, 10'h3FF};
        vecs[8] = '{C_SETADDR, 10'h005, 32'h0,        10'h005, 1'b0, 16'd3, 32'h00000013, 0, 10'h000};

        for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = '0;

        // Reset state
        idle(3);
        tap_rst_s = 1'b0;
        idle(2);
        chk("rst_hold", cpu_hold_o, 0);
        chk("rst_sel", imem_sel_o, 0);
        chk("rst_wr", imem_wr_o, 0);
        chk("rst_restart", cpu_restart_o, 0);
        chk("rst_addr", imem_addr_o, 0);
        chk("rst_status", status_o[63:0], 0);
        $display("reset released: status=0x%0h", status_o);

        // WRITE in IDLE: flagged and dropped
        wr_before = wr_total;
        send(C_WRITE, 10'h001, 32'h12345678);
        idle(3);
        chk("idle_write_err", s_err(status_o), 1);
        chk("idle_write_nowr", wr_total - wr_before, 0);
        $display("WRITE in IDLE: cmd_err=%0b", s_err(status_o));

        // Ownership handshake
        send(C_OPEN, 10'h0, 32'h0);
        chk("open_hold", cpu_hold_o, 1);
        chk("open_sel", imem_sel_o, 0);
        idle(4);
        chk("hold_wait_sel", imem_sel_o, 0);
        chk("hold_wait_err_clr", s_err(status_o), 0);
        chk("hold_wait_state", s_state(status_o), 1);
        cpu_ack_i = 1'b1;
        idle(2);
        chk("ack_sel_early", imem_sel_o, 0);
        idle(1);
        chk("ack_sel_on", imem_sel_o, 1);
        idle(1);
        chk("own_state", s_state(status_o), 2);
        chk("own_owned", s_owned(status_o), 1);
        $display("OPEN + ack: sel=%0b state=%0d", imem_sel_o, s_state(status_o));

        // Table of owned-mode commands
        for (int i = 0; i < 9; i++) begin
            wr_before = wr_total;
            send(vecs[i].op, vecs[i].addr, vecs[i].data);
            idle(4);
            chk($sformatf("v%0d_ptr", i), s_ptr(status_o), vecs[i].exp_ptr);
            chk($sformatf("v%0d_wrap", i), s_wrap(status_o), vecs[i].exp_wrap);
            chk($sformatf("v%0d_cnt", i), s_cnt(status_o), vecs[i].exp_cnt);
            chk($sformatf("v%0d_rdata", i), s_rdata(status_o), vecs[i].exp_rdata);
            chk($sformatf("v%0d_wrpulses", i), wr_total - wr_before, vecs[i].exp_wr);
            if (vecs[i].exp_wr != 0) begin
                chk($sformatf("v%0d_wraddr", i), last_wr_addr, vecs[i].exp_wr_addr);
                chk($sformatf("v%0d_wrdata", i), last_wr_data, vecs[i].data);
            end
            $display("vec %0d op=%0d addr=0x%03h data=0x%08h -> ptr=0x%03h wrap=%0b cnt=%0d rdata=0x%08h",
                     i, vecs[i].op, vecs[i].addr, vecs[i].data, s_ptr(status_o),
                     s_wrap(status_o), s_cnt(status_o), s_rdata(status_o));
        end

        // Overrun: upd_i on two consecutive cycles, second lands in WRITE
        wr_before = wr_total;
        cmd_i = {10'h0, 32'hA5A5A5A5, C_WRITE};
        upd_i = 1'b1;
        @(negedge tck_i);
        cmd_i = {10'h0, 32'h5A5A5A5A, C_WRITE};
        @(negedge tck_i);
        upd_i = 1'b0;
        idle(4);
        chk("ovr_flag", s_ovr(status_o), 1);
        chk("ovr_wrpulses", wr_total - wr_before, 1);
        chk("ovr_wrdata", last_wr_data, 32'hA5A5A5A5);
        chk("ovr_ptr", s_ptr(status_o), 10'h006);
        chk("ovr_cnt", s_cnt(status_o), 4);
        $display("overrun: ovr=%0b writes=%0d", s_ovr(status_o), wr_total - wr_before);

        // Release
        rs_before = restart_total;
        send(C_CLOSE, 10'h0, 32'h0);
        chk("rel1_sel", imem_sel_o, 0);
        chk("rel1_hold", cpu_hold_o, 1);
        chk("rel1_restart", cpu_restart_o, 0);
        idle(1);
        chk("rel2_hold", cpu_hold_o, 0);
        chk("rel2_restart", cpu_restart_o, 1);
        idle(1);
        chk("rel3_restart", cpu_restart_o, 0);
        chk("rel3_state", s_state(status_o), 0);
        chk("rel_restart_pulses", restart_total - rs_before, 1);
        cpu_ack_i = 1'b0;
        $display("CLOSE: hold=%0b state=%0d", cpu_hold_o, s_state(status_o));

        // Illegal opcode in IDLE
        send(C_ILL7, 10'h0, 32'h0);
        idle(3);
        chk("ill7_err", s_err(status_o), 1);
        chk("ill7_state", s_state(status_o), 0);
        $display("opcode 111: cmd_err=%0b", s_err(status_o));

        // Reset in the middle of a WRITE
        send(C_OPEN, 10'h0, 32'h0);
        cpu_ack_i = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge tck_i);
            if (imem_sel_o) got = 1'b1;
        end
        chk("rst2_own_timeout", got, 1);
        rs_before = restart_total;
        send(C_WRITE, 10'h0, 32'hCAFEF00D);
        chk("rst2_wr_active", imem_wr_o, 1);
        #2 tap_rst_s = 1'b1;
        #1;
        chk("rst2_wr", imem_wr_o, 0);
        chk("rst2_sel", imem_sel_o, 0);
        chk("rst2_hold", cpu_hold_o, 0);
        chk("rst2_status", status_o[63:0], 0);
        idle(3);
        tap_rst_s = 1'b0;
        idle(3);
        chk("rst2_no_restart", restart_total - rs_before, 0);
        chk("rst2_hold_after", cpu_hold_o, 0);
        chk("rst2_ptr", imem_addr_o, 0);
        $display("reset mid-write: wr=%0b sel=%0b hold=%0b", imem_wr_o, imem_sel_o, cpu_hold_o);

        chk("invariants", inv_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
